// File: rtl/tdc_readout_mux_pkg.sv
// tdc_readout_mux_pkg: word layout shared by tdc_readout_mux and its arbiter.
// TDC_COARSE_TS_EN (undefined by default) enables the coarse timestamp field.
package tdc_readout_mux_pkg;
    localparam int WORD_W = 32;
    localparam int CH_W_DEF = 4;
    localparam int TDC_W_DEF = 20;
`ifdef TDC_COARSE_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    function automatic int ts_w(input int ch_w, input int tdc_w);
        return WORD_W - ch_w - tdc_w;
    endfunction
    function automatic int tdc_off();
        return 0;
    endfunction
    function automatic int ts_off(input int tdc_w);
        return tdc_w;
    endfunction
    function automatic int ch_off(input int ch_w);
        return WORD_W - ch_w;
    endfunction
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/tdc_readout_mux_arbiter.sv
// rr_arbiter: combinational search for the first request at or after ptr, with wrap.
module rr_arbiter
    import tdc_readout_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req,
    input  logic            en,
    input  logic [PW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            vld
);
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (en && !vld && req[rr_index(int'(ptr), i, N_CH)]) begin
                vld = 1'b1;
                idx = PW'(rr_index(int'(ptr), i, N_CH));
                gnt[rr_index(int'(ptr), i, N_CH)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdc_readout_mux.sv
// tdc_readout_mux: round-robin readout of N_CH TDC channels into tagged 32-bit FIFO words.
// Define TDC_COARSE_TS_EN to stamp each word with a free-running coarse timestamp.
module tdc_readout_mux
    import tdc_readout_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int TDC_W = TDC_W_DEF,
    parameter int CH_W = CH_W_DEF,
    parameter int DROP_W = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [N_CH*TDC_W-1:0] iTdc,
    input  logic [N_CH-1:0]       iDone,
    input  logic                  iAlmostFull,
    input  logic                  iWriteErr,
    input  logic                  iReadErr,
    input  logic                  iClearErr,
    output logic                  oWriteEN,
    output logic [WORD_W-1:0]     oWord,
    output logic [DROP_W-1:0]     oDropCnt,
    output logic                  oWriteERR,
    output logic                  oReadERR
);
    localparam int TS_W = ts_w(CH_W, TDC_W);
    localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  pend, gnt, cap, drop;
    logic [PW-1:0]    ptr, g_idx, next_ptr;
    logic             g_vld;
    logic [TDC_W-1:0] data [N_CH];
    logic [TS_W-1:0]  ts_field;
    logic [DROP_W+4:0] drop_sum;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req(pend),
        .en(!iAlmostFull),
        .ptr(ptr),
        .gnt(gnt),
        .idx(g_idx),
        .vld(g_vld)
    );

    // A slot being granted this cycle is free again, so it may recapture.
    assign cap = iDone & (~pend | gnt);
    assign drop = iDone & pend & ~gnt;
    assign next_ptr = (g_idx == PW'(N_CH - 1)) ? '0 : g_idx + 1'b1;

    always_comb begin
        drop_sum = {5'd0, oDropCnt};
        for (int k = 0; k < N_CH; k++) drop_sum += (DROP_W + 5)'(drop[k]);
    end

    always_ff @(posedge iClk) begin
        for (int k = 0; k < N_CH; k++)
            if (cap[k]) data[k] <= iTdc[k*TDC_W +: TDC_W];
    end

`ifdef TDC_COARSE_TS_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q [N_CH];
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) ts_cnt <= '0;
        else ts_cnt <= ts_cnt + 1'b1;
    end
    always_ff @(posedge iClk) begin
        for (int k = 0; k < N_CH; k++)
            if (cap[k]) ts_q[k] <= ts_cnt;
    end
    assign ts_field = TS_EN ? ts_q[g_idx] : '0;
`else
    assign ts_field = '0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pend <= '0;
            ptr <= '0;
            oWriteEN <= 1'b0;
            oWord <= '0;
            oDropCnt <= '0;
            oWriteERR <= 1'b0;
            oReadERR <= 1'b0;
        end else begin
            pend <= cap | (pend & ~gnt);
            oWriteEN <= g_vld;
            if (g_vld) begin
                ptr <= next_ptr;
                oWord <= {CH_W'(g_idx), ts_field, data[g_idx]};
            end
            oDropCnt <= iClearErr ? '0 : (|drop_sum[DROP_W+4:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
            oWriteERR <= iWriteErr | (oWriteERR & ~iClearErr);
            oReadERR <= iReadErr | (oReadERR & ~iClearErr);
        end
    end
endmodule

// File: tb/tb_tdc_readout_mux.sv
// tb_tdc_readout_mux: directed self-checking bench for tdc_readout_mux (N_CH=4, DROP_W=2).
module tb_tdc_readout_mux;
    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [79:0] iTdc = '0;
    logic [3:0]  iDone = '0;
    logic        iAlmostFull = 1'b0;
    logic        iWriteErr = 1'b0;
    logic        iReadErr = 1'b0;
    logic        iClearErr = 1'b0;
    logic        oWriteEN;
    logic [31:0] oWord;
    logic [1:0]  oDropCnt;
    logic        oWriteERR;
    logic        oReadERR;
    int nt = 0;
    int nf = 0;

    tdc_readout_mux #(.N_CH(4), .TDC_W(20), .CH_W(4), .DROP_W(2)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iTdc(iTdc),
        .iDone(iDone),
        .iAlmostFull(iAlmostFull),
        .iWriteErr(iWriteErr),
        .iReadErr(iReadErr),
        .iClearErr(iClearErr),
        .oWriteEN(oWriteEN),
        .oWord(oWord),
        .oDropCnt(oDropCnt),
        .oWriteERR(oWriteERR),
        .oReadERR(oReadERR)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(negedge iClk);
    endtask

    task automatic apply_reset();
        iDone = '0;
        iAlmostFull = 1'b0;
        iWriteErr = 1'b0;
        iReadErr = 1'b0;
        iClearErr = 1'b0;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        tick();
        nt++;
        if ({oWriteEN, oWord, oDropCnt, oWriteERR, oReadERR} !== 37'd0) begin
            nf++;
            $display("FAIL reset_state got we=%0b word=%h drop=%0d werr=%0b rerr=%0b exp all 0",
                     oWriteEN, oWord, oDropCnt, oWriteERR, oReadERR);
        end
        iRst = 1'b0;
        tick();
        tick();
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL idle_no_write got %0b exp 0", oWriteEN);
        end
    endtask

    task automatic test_single_hit();
        apply_reset();
        iTdc[2*20 +: 20] = 20'h12345;
        iDone = 4'b0100;
        tick();
        iDone = '0;
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL single_early got we=%0b exp 0", oWriteEN);
        end
        tick();
        nt++;
        if (oWriteEN !== 1'b1 || oWord[31:28] !== 4'd2 || oWord[19:0] !== 20'h12345) begin
            nf++;
            $display("FAIL single_word got we=%0b word=%h exp we=1 ch=2 data=12345", oWriteEN, oWord);
        end
`ifndef TDC_COARSE_TS_EN
        nt++;
        if (oWord[27:20] !== 8'd0) begin
            nf++;
            $display("FAIL single_ts_zero got %h exp 00", oWord[27:20]);
        end
`endif
        tick();
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL single_one_pulse got we=%0b exp 0", oWriteEN);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_ch [6];
        logic [19:0] exp_d [6];
        exp_ch = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3};
        exp_d = '{20'hA0000, 20'hA0001, 20'hA0002, 20'hA0003, 20'hB0000, 20'hB0003};
        apply_reset();
        for (int k = 0; k < 4; k++) iTdc[k*20 +: 20] = 20'hA0000 + 20'(k);
        iDone = 4'b1111;
        tick();
        iDone = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            nt++;
            if (oWriteEN !== 1'b1 || oWord[31:28] !== exp_ch[i] || oWord[19:0] !== exp_d[i]) begin
                nf++;
                $display("FAIL burst_%0d got we=%0b ch=%0d data=%h exp we=1 ch=%0d data=%h",
                         i, oWriteEN, oWord[31:28], oWord[19:0], exp_ch[i], exp_d[i]);
            end
            tick();
        end
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL burst_end got we=%0b exp 0", oWriteEN);
        end
        iTdc[0 +: 20] = 20'hB0000;
        iTdc[60 +: 20] = 20'hB0003;
        iDone = 4'b1001;
        tick();
        iDone = '0;
        tick();
        for (int i = 4; i < 6; i++) begin
            nt++;
            if (oWriteEN !== 1'b1 || oWord[31:28] !== exp_ch[i] || oWord[19:0] !== exp_d[i]) begin
                nf++;
                $display("FAIL ptr_wrap_%0d got we=%0b ch=%0d data=%h exp we=1 ch=%0d data=%h",
                         i, oWriteEN, oWord[31:28], oWord[19:0], exp_ch[i], exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        iAlmostFull = 1'b1;
        iTdc[20 +: 20] = 20'h11111;
        iDone = 4'b0010;
        tick();
        iTdc[20 +: 20] = 20'h22222;
        tick();
        iDone = '0;
        tick();
        nt++;
        if (oWriteEN !== 1'b0 || oDropCnt !== 2'd1) begin
            nf++;
            $display("FAIL bp_hold got we=%0b drop=%0d exp we=0 drop=1", oWriteEN, oDropCnt);
        end
        iAlmostFull = 1'b0;
        tick();
        nt++;
        if (oWriteEN !== 1'b1 || oWord[31:28] !== 4'd1 || oWord[19:0] !== 20'h11111) begin
            nf++;
            $display("FAIL bp_release got we=%0b word=%h exp we=1 ch=1 data=11111", oWriteEN, oWord);
        end
        tick();
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL bp_single got we=%0b exp 0", oWriteEN);
        end
    endtask

    task automatic test_recapture();
        apply_reset();
        iTdc[0 +: 20] = 20'h0AAAA;
        iDone = 4'b0001;
        tick();
        iTdc[0 +: 20] = 20'h0BBBB;
        tick();
        iDone = '0;
        nt++;
        if (oWriteEN !== 1'b1 || oWord[19:0] !== 20'h0AAAA) begin
            nf++;
            $display("FAIL recap_first got we=%0b word=%h exp we=1 data=0aaaa", oWriteEN, oWord);
        end
        tick();
        nt++;
        if (oWriteEN !== 1'b1 || oWord[31:28] !== 4'd0 || oWord[19:0] !== 20'h0BBBB) begin
            nf++;
            $display("FAIL recap_second got we=%0b word=%h exp we=1 ch=0 data=0bbbb", oWriteEN, oWord);
        end
        nt++;
        if (oDropCnt !== 2'd0) begin
            nf++;
            $display("FAIL recap_no_drop got %0d exp 0", oDropCnt);
        end
        tick();
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL recap_end got we=%0b exp 0", oWriteEN);
        end
    endtask

    task automatic test_saturation_clear();
        apply_reset();
        iAlmostFull = 1'b1;
        iDone = 4'b0001;
        tick();
        iDone = 4'b1111;
        tick();
        nt++;
        if (oDropCnt !== 2'd1) begin
            nf++;
            $display("FAIL sat_first got %0d exp 1", oDropCnt);
        end
        tick();
        iDone = '0;
        nt++;
        if (oDropCnt !== 2'd3) begin
            nf++;
            $display("FAIL sat_hold got %0d exp 3", oDropCnt);
        end
        iClearErr = 1'b1;
        iWriteErr = 1'b1;
        tick();
        iClearErr = 1'b0;
        iWriteErr = 1'b0;
        nt++;
        if (oDropCnt !== 2'd0 || oWriteERR !== 1'b1) begin
            nf++;
            $display("FAIL clear_vs_set got drop=%0d werr=%0b exp drop=0 werr=1", oDropCnt, oWriteERR);
        end
        tick();
        nt++;
        if (oWriteERR !== 1'b1 || oReadERR !== 1'b0) begin
            nf++;
            $display("FAIL werr_sticky got werr=%0b rerr=%0b exp werr=1 rerr=0", oWriteERR, oReadERR);
        end
    endtask

    task automatic test_read_err();
        apply_reset();
        iReadErr = 1'b1;
        tick();
        iReadErr = 1'b0;
        tick();
        nt++;
        if (oReadERR !== 1'b1 || oWriteERR !== 1'b0) begin
            nf++;
            $display("FAIL rerr_set got rerr=%0b werr=%0b exp rerr=1 werr=0", oReadERR, oWriteERR);
        end
        iClearErr = 1'b1;
        tick();
        iClearErr = 1'b0;
        nt++;
        if (oReadERR !== 1'b0) begin
            nf++;
            $display("FAIL rerr_clear got %0b exp 0", oReadERR);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        iTdc[60 +: 20] = 20'h33333;
        iDone = 4'b1000;
        tick();
        iDone = '0;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        nt++;
        if (oWriteEN !== 1'b0) begin
            nf++;
            $display("FAIL midrst_during got we=%0b exp 0", oWriteEN);
        end
        tick();
        tick();
        nt++;
        if (oWriteEN !== 1'b0 || oDropCnt !== 2'd0) begin
            nf++;
            $display("FAIL midrst_discard got we=%0b drop=%0d exp we=0 drop=0", oWriteEN, oDropCnt);
        end
    endtask

    task automatic test_timestamp();
        logic [7:0] ts1, ts2;
        apply_reset();
        iDone = 4'b0001;
        tick();
        iDone = '0;
        tick();
        ts1 = oWord[27:20];
        for (int i = 0; i < 13; i++) tick();
        iDone = 4'b0001;
        tick();
        iDone = '0;
        tick();
        ts2 = oWord[27:20];
        nt++;
        if (oWriteEN !== 1'b1) begin
            nf++;
            $display("FAIL ts_write got we=%0b exp 1", oWriteEN);
        end
`ifdef TDC_COARSE_TS_EN
        nt++;
        if (8'(ts2 - ts1) !== 8'd15) begin
            nf++;
            $display("FAIL ts_delta got %0d exp 15", 8'(ts2 - ts1));
        end
`else
        nt++;
        if (ts1 !== 8'd0 || ts2 !== 8'd0) begin
            nf++;
            $display("FAIL ts_zero got %h/%h exp 00/00", ts1, ts2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_back_pressure();
        test_recapture();
        test_saturation_clear();
        test_read_err();
        test_reset_midop();
        test_timestamp();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
